// File: rtl/input_capture_mc_pkg.sv
// Shared definitions for the multi-channel input capture block.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package input_capture_pkg;

  // Edge-select encoding, two bits per channel
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  // FIFO pointer width; a depth of 1 still needs a 1-bit pointer
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Channel-select width; a single channel still gets a 1-bit select
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_capture_mc_if.sv
// Pop/status bus between the capture block and the control_logic front-end.
// Latency: a pop issued in cycle n returns data in cycle n+1.
// Backpressure: none; an empty or out-of-range pop simply returns o_rd_valid=0.
interface input_capture_mc_if
  import input_capture_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int CH_NUM  = 4,
  parameter int RD_CH_W = sel_width(CH_NUM)
);
  logic               i_rd;
  logic [RD_CH_W-1:0] i_rd_ch;
  logic [CNT_W-1:0]   o_rd_data;
  logic               o_rd_valid;
  logic [CH_NUM-1:0]  o_ic_flg;
  logic [CH_NUM-1:0]  o_ovf;

  // Bus front-end side
  modport master (
    output i_rd, i_rd_ch,
    input  o_rd_data, o_rd_valid, o_ic_flg, o_ovf
  );

  // Capture block side
  modport slave (
    input  i_rd, i_rd_ch,
    output o_rd_data, o_rd_valid, o_ic_flg, o_ovf
  );
endinterface

// File: rtl/input_capture_mc_chan.sv
// One capture channel: pin synchroniser, edge detector, snapshot FIFO, sticky overflow.
// Latency: pin change sampled at edge k is pushed at edge k+SYNC_STAGES, flagged right after.
// Backpressure: a full FIFO drops the new capture and sets ovf unless a pop frees a slot that cycle.
module ic_chan
  import input_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             armed,
  input  logic             cap_pin,
  input  logic             ch_en,
  input  logic [1:0]       edge_sel,
  input  logic             ch_clr,
  input  logic             pop_req,
  input  logic [CNT_W-1:0] cap_val,
  output logic             pop_ok,
  output logic [CNT_W-1:0] head_data,
  output logic             not_empty,
  output logic             ovf
);
  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   fall;
  logic                   edge_hit;
  edge_sel_e              sel;

  logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             ovf_q;

  logic full;
  logic empty;
  logic push_req;
  logic push_ok;
  logic ovf_set;

  // Shift the asynchronous pin through the synchroniser; history trails the last stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;
  assign sel  = edge_sel_e'(edge_sel);

  // Qualify the raw transitions with the live edge select
  always_comb begin
    edge_hit = 1'b0;
    case (sel)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      EDGE_BOTH: edge_hit = rise | fall;
      default:   edge_hit = 1'b0;
    endcase
  end

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = armed & ch_en & edge_hit & ~ch_clr;
  assign pop_ok   = pop_req & ~ch_clr & ~empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push
  assign push_ok  = push_req & (~full | pop_ok);
  assign ovf_set  = push_req & full & ~pop_ok;

  // Snapshot storage; contents are meaningless outside the occupied window so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= cap_val;
    end
  end

  // Pointer and occupancy bookkeeping; a flush discards any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (!rst_n || ch_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow, cleared only by flush or reset
  always_ff @(posedge clk) begin
    if (!rst_n || ch_clr) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = ~empty;
  assign ovf       = ovf_q;

endmodule

// File: rtl/input_capture_mc.sv
// Multi-channel input capture: shared prescaled timebase, per-channel capture FIFOs, indexed pop.
// Latency: pop data one cycle after i_rd; capture visible SYNC_STAGES+1 cycles after the pin edge.
// Backpressure: none on the pop side; full FIFOs drop new captures and raise o_ovf.
module input_capture_mc
  import input_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int CH_NUM      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sysclk,
  input  logic                  i_sysrst,
  input  logic                  i_cnt_en,
  input  logic                  i_cnt_clr,
  input  logic                  i_prs_tick,
  input  logic [CH_NUM-1:0]     i_cap_pin,
  input  logic [CH_NUM-1:0]     i_ch_en,
  input  logic [2*CH_NUM-1:0]   i_edge_sel,
  input  logic [CH_NUM-1:0]     i_ch_clr,
  input_capture_mc_if.slave     bus,
  output logic [CNT_W-1:0]      o_cnt_data,
  output logic                  o_cnt_wrap
);
  localparam int SEL_W = sel_width(CH_NUM);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic              wrap_q;
  logic [ARM_W-1:0]  arm_q;
  logic              armed;

  logic [CH_NUM-1:0] pop_sel;
  logic [CH_NUM-1:0] pop_ok;
  logic [CH_NUM-1:0] not_empty;
  logic [CH_NUM-1:0] ovf;
  logic [CNT_W-1:0]  head_arr [CH_NUM];
  logic [CNT_W-1:0]  sel_data;

  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_valid_q;

  // Free-running timebase; clear wins and never produces a wrap pulse
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (i_cnt_clr) begin
        cnt_q <= '0;
      end else if (i_cnt_en && i_prs_tick) begin
        cnt_q  <= cnt_q + 1'b1;
        wrap_q <= &cnt_q;
      end
    end
  end

  // Hold off detection until the synchronisers and history flops hold real pin data
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst) begin
      arm_q <= '0;
    end else if (arm_q != ARM_MAX) begin
      arm_q <= arm_q + 1'b1;
    end
  end

  assign armed = (arm_q == ARM_MAX);

  // Decode the pop index; out-of-range indices match no channel
  always_comb begin
    pop_sel = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      pop_sel[c] = bus.i_rd && (bus.i_rd_ch == SEL_W'(c));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    ic_chan #(
      .CNT_W      (CNT_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk      (i_sysclk),
      .rst_n    (i_sysrst),
      .armed    (armed),
      .cap_pin  (i_cap_pin[g]),
      .ch_en    (i_ch_en[g]),
      .edge_sel (i_edge_sel[2*g+1:2*g]),
      .ch_clr   (i_ch_clr[g]),
      .pop_req  (pop_sel[g]),
      .cap_val  (cnt_q),
      .pop_ok   (pop_ok[g]),
      .head_data(head_arr[g]),
      .not_empty(not_empty[g]),
      .ovf      (ovf[g])
    );
  end

  // At most one channel pops per cycle, so a priority-free OR-style select suffices
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (pop_ok[c]) sel_data = head_arr[c];
    end
  end

  // Registered read port; data holds when nothing was popped
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= |pop_ok;
      if (|pop_ok) rd_data_q <= sel_data;
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_ic_flg   = not_empty;
  assign bus.o_ovf      = ovf;
  assign o_cnt_data     = cnt_q;
  assign o_cnt_wrap     = wrap_q;

endmodule

// File: tb/tb_input_capture_mc.sv
// Self-checking bench for input_capture_mc against a queue-style behavioural model.
// Latency: model predicts each output one cycle at a time.
// Backpressure: not applicable.
module tb_input_capture_mc;
  localparam int CNT_W = 16;
  localparam int CH    = 4;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cnt_en;
  logic              cnt_clr;
  logic              prs_tick;
  logic [CH-1:0]     cap_pin;
  logic [CH-1:0]     ch_en;
  logic [2*CH-1:0]   edge_sel;
  logic [CH-1:0]     ch_clr;
  logic [CNT_W-1:0]  cnt_data;
  logic              cnt_wrap;

  input_capture_mc_if #(.CNT_W(CNT_W), .CH_NUM(CH), .RD_CH_W(2)) bus ();

  input_capture_mc #(
    .CNT_W(CNT_W), .CH_NUM(CH), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(S)
  ) dut (
    .i_sysclk  (clk),
    .i_sysrst  (rst_n),
    .i_cnt_en  (cnt_en),
    .i_cnt_clr (cnt_clr),
    .i_prs_tick(prs_tick),
    .i_cap_pin (cap_pin),
    .i_ch_en   (ch_en),
    .i_edge_sel(edge_sel),
    .i_ch_clr  (ch_clr),
    .bus       (bus),
    .o_cnt_data(cnt_data),
    .o_cnt_wrap(cnt_wrap)
  );

  always #5 clk = ~clk;

  // Pending pin transitions, each tagged with the edge number at which it is detected
  typedef struct {
    int unsigned cyc;
    int          ch;
    bit          rise;
  } ev_t;

  ev_t              evq[$];
  int unsigned      ecount = 0;
  int unsigned      rel_edge = 0;
  logic [CNT_W-1:0] m_cnt;
  bit               m_wrap;
  bit               m_rd_valid;
  logic [CNT_W-1:0] m_rd_data;
  logic [CNT_W-1:0] m_fifo [CH][DEPTH];
  int               m_occ [CH];
  bit               m_ovf [CH];
  bit               m_pin_seen [CH];
  int               n_chk = 0;
  int               n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit sel_match(input logic [1:0] s, input bit rise);
    return (s == 2'b11) || (s == 2'b01 && rise) || (s == 2'b10 && !rise);
  endfunction

  task automatic check_all();
    chk("cnt_data", cnt_data, m_cnt);
    chk("cnt_wrap", cnt_wrap, m_wrap);
    chk("rd_valid", bus.o_rd_valid, m_rd_valid);
    chk("rd_data", bus.o_rd_data, m_rd_data);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("ic_flg%0d", c), bus.o_ic_flg[c], m_occ[c] != 0);
      chk($sformatf("ovf%0d", c), bus.o_ovf[c], m_ovf[c]);
    end
  endtask

  // Advance one clock: predict the post-edge state from the pre-edge inputs, then compare
  task automatic step();
    int unsigned k;
    int          rc;
    bit          nv;
    ev_t         ev;
    k = ecount + 1;
    if (!rst_n) begin
      m_cnt = '0; m_wrap = 0; m_rd_valid = 0; m_rd_data = '0;
      for (int c = 0; c < CH; c++) begin
        m_occ[c] = 0; m_ovf[c] = 0; m_pin_seen[c] = 0;
      end
      evq.delete();
      rel_edge = k + 1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (cap_pin[c] != m_pin_seen[c]) begin
          ev.cyc = k + S; ev.ch = c; ev.rise = cap_pin[c];
          evq.push_back(ev);
          m_pin_seen[c] = cap_pin[c];
        end
      end
      nv = 0;
      rc = int'(bus.i_rd_ch);
      if (bus.i_rd && rc < CH && !ch_clr[rc] && m_occ[rc] > 0) begin
        nv = 1;
        m_rd_data = m_fifo[rc][0];
        for (int i = 0; i < DEPTH - 1; i++) m_fifo[rc][i] = m_fifo[rc][i+1];
        m_occ[rc]--;
      end
      while (evq.size() > 0 && evq[0].cyc == k) begin
        ev = evq.pop_front();
        if (k > rel_edge + S && ch_en[ev.ch] && !ch_clr[ev.ch] &&
            sel_match(edge_sel[2*ev.ch +: 2], ev.rise)) begin
          if (m_occ[ev.ch] < DEPTH) begin
            m_fifo[ev.ch][m_occ[ev.ch]] = m_cnt;
            m_occ[ev.ch]++;
          end else begin
            m_ovf[ev.ch] = 1;
          end
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (ch_clr[c]) begin m_occ[c] = 0; m_ovf[c] = 0; end
      end
      m_rd_valid = nv;
      m_wrap = 0;
      if (cnt_clr) m_cnt = '0;
      else if (cnt_en && prs_tick) begin
        if (m_cnt == CMAX) m_wrap = 1;
        m_cnt = m_cnt + 1'b1;
      end
    end
    @(posedge clk);
    ecount = k;
    #1;
    check_all();
  endtask

  task automatic pop(input int c);
    bus.i_rd = 1'b1; bus.i_rd_ch = 2'(c);
    step();
    bus.i_rd = 1'b0;
  endtask

  logic [CNT_W-1:0] prev, diff, last, nv_exp, v0;
  int               n_valid;

  initial begin
    rst_n = 0; cnt_en = 0; cnt_clr = 0; prs_tick = 0;
    cap_pin = 4'b0001; ch_en = 4'hF; edge_sel = 8'b0000_0001; ch_clr = '0;
    bus.i_rd = 0; bus.i_rd_ch = '0;

    // Pin 0 held high through reset must not be captured once armed
    repeat (3) step();
    rst_n = 1;
    repeat (10) begin
      step();
      chk("arm_flg0", bus.o_ic_flg[0], 1'b0);
      chk("arm_cnt", cnt_data, 16'h0000);
    end

    // Capture latency and value
    cnt_en = 1; prs_tick = 1;
    for (int i = 0; i < 100 && m_cnt != 16'h0010; i++) step();
    edge_sel[3:2] = 2'b01; cap_pin[1] = 1'b1;
    repeat (S + 1) step();
    chk("lat_flg1", bus.o_ic_flg[1], 1'b1);
    pop(1);
    chk("lat_valid", bus.o_rd_valid, 1'b1);
    chk("lat_value", bus.o_rd_data, 16'h0010 + S);
    chk("lat_flg1_after", bus.o_ic_flg[1], 1'b0);

    // Both edges on ch2, six captures into a four-deep FIFO
    edge_sel[5:4] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      cap_pin[2] = ~cap_pin[2];
      repeat (20) step();
    end
    chk("ovf2_set", bus.o_ovf[2], 1'b1);
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      pop(2);
      chk("ovf2_pop_valid", bus.o_rd_valid, 1'b1);
      diff = bus.o_rd_data - prev;
      if (i > 0) chk("ovf2_gap", diff, 16'd20);
      prev = bus.o_rd_data;
    end
    pop(2);
    chk("ovf2_empty_pop", bus.o_rd_valid, 1'b0);

    // ch0 full, pop lands in the same cycle as a new detection
    edge_sel[1:0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cap_pin[0] = ~cap_pin[0];
      repeat ($urandom_range(2, 6)) step();
    end
    repeat (S + 2) step();
    chk("full0_flg", bus.o_ic_flg[0], 1'b1);
    cap_pin[0] = ~cap_pin[0];
    repeat (S) step();
    pop(0);
    chk("pp_ovf0", bus.o_ovf[0], 1'b0);
    chk("pp_valid", bus.o_rd_valid, 1'b1);
    nv_exp = m_fifo[0][DEPTH-1];
    n_valid = 0; last = '0;
    repeat (5) begin
      pop(0);
      if (bus.o_rd_valid === 1'b1) begin n_valid++; last = bus.o_rd_data; end
    end
    chk("pp_count", n_valid, 4);
    chk("pp_last", last, nv_exp);

    // Clear together with tick at 0x1234
    for (int i = 0; i < 70000 && m_cnt != 16'h1234; i++) step();
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_cnt", cnt_data, 16'h0000);
    chk("clr_nowrap", cnt_wrap, 1'b0);

    // Wrap from 0xFFFF
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step();
    step();
    chk("wrap_cnt", cnt_data, 16'h0000);
    chk("wrap_pulse", cnt_wrap, 1'b1);
    step();
    chk("wrap_pulse_end", cnt_wrap, 1'b0);

    // ch3 flush while ch0 captures
    edge_sel[7:6] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cap_pin[3] = ~cap_pin[3];
      repeat (6) step();
    end
    repeat (S + 2) step();
    pop(3);
    pop(3);
    chk("flush_ovf3_before", bus.o_ovf[3], 1'b1);
    cap_pin[0] = ~cap_pin[0];
    repeat (S) step();
    ch_clr = 4'b1000;
    step();
    ch_clr = '0;
    chk("flush_flg3", bus.o_ic_flg[3], 1'b0);
    chk("flush_ovf3", bus.o_ovf[3], 1'b0);
    chk("iso_flg0", bus.o_ic_flg[0], 1'b1);
    pop(0);
    chk("iso_valid0", bus.o_rd_valid, 1'b1);

    // Disabled channel ignores edges
    ch_en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap_pin[0] = ~cap_pin[0];
      repeat (3) step();
    end
    repeat (S + 3) step();
    chk("dis_flg0", bus.o_ic_flg[0], 1'b0);

    // Simultaneous edges on every channel share one timestamp
    ch_en = 4'hF; edge_sel = 8'hFF;
    cap_pin = ~cap_pin;
    repeat (S + 1) step();
    pop(0);
    v0 = bus.o_rd_data;
    chk("sim_valid0", bus.o_rd_valid, 1'b1);
    for (int c = 1; c < CH; c++) begin
      pop(c);
      chk($sformatf("sim_same%0d", c), bus.o_rd_data, v0);
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < 15) cap_pin[c] = ~cap_pin[c];
      end
      if ($urandom_range(0, 99) < 5) edge_sel = 8'($urandom);
      ch_en    = ($urandom_range(0, 99) < 10) ? 4'($urandom) : 4'hF;
      ch_clr   = ($urandom_range(0, 99) < 3) ? 4'($urandom) : 4'h0;
      prs_tick = 1'($urandom);
      cnt_en   = ($urandom_range(0, 99) < 90);
      cnt_clr  = ($urandom_range(0, 99) < 2);
      bus.i_rd = ($urandom_range(0, 99) < 30);
      bus.i_rd_ch = 2'($urandom_range(0, 3));
      step();
    end
    bus.i_rd = 0; ch_clr = '0; cnt_clr = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
